// File: rtl/rd_kgp_pkg.sv
// -----------------------------------------------------------------------------
// rd_kgp_pkg
//   Shared definitions for the kgp (kill / generate / propagate) recursive-
//   doubling carry tree used by the subtractor.
//   - WIDTH / LEVELS : operand width and number of doubling levels (fixed).
//   - KGP_* codes    : 2-bit carry-status encoding, one code per bit position.
//   - kgp_combine    : prefix operator merging an upper span with a lower span.
// -----------------------------------------------------------------------------
package rd_kgp_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LEVELS = 5;

  localparam logic [1:0] KGP_KILL = 2'b00;
  localparam logic [1:0] KGP_GEN  = 2'b01;
  localparam logic [1:0] KGP_PROP = 2'b11;

  typedef logic [1:0]          kgp_t;
  typedef kgp_t [WIDTH-1:0]    kgp_vec_t;

  // Upper span decides unless it propagates, in which case the lower span's
  // status shows through. Code 2'b10 is never produced; OR-ing in bit 0 folds
  // it onto PROP so it behaves the same way.
  function automatic kgp_t kgp_combine(input kgp_t u, input kgp_t l);
    return ((u | 2'b01) == KGP_PROP) ? l : u;
  endfunction

endpackage

// File: rtl/rd_kgp_level.sv
// -----------------------------------------------------------------------------
// rd_kgp_level
//   One row of the recursive-doubling tree: every bit i >= SPAN combines its
//   own span with the span SPAN positions below it. Bits below SPAN already
//   cover everything down to bit 0 and pass straight through.
//   Ports:
//     kgp_i  in   WIDTH x 2  kgp codes entering this level
//     kgp_o  out  WIDTH x 2  kgp codes after combining at distance SPAN
// -----------------------------------------------------------------------------
module rd_kgp_level
  import rd_kgp_pkg::*;
#(
  parameter int unsigned SPAN = 1
) (
  input  kgp_vec_t kgp_i,
  output kgp_vec_t kgp_o
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    if (i < int'(SPAN)) begin : g_pass
      assign kgp_o[i] = kgp_i[i];
    end else begin : g_comb
      assign kgp_o[i] = kgp_combine(kgp_i[i], kgp_i[i-int'(SPAN)]);
    end
  end

endmodule

// File: rtl/rd_prefix_subtractor.sv
// -----------------------------------------------------------------------------
// rd_prefix_subtractor
//   Three-stage pipelined 32-bit subtractor, diff = a - b - bin, computed as
//   a + ~b + ~bin on a kgp recursive-doubling carry tree.
//     S1: levels 1,2 registered with a, ~b, cin
//     S2: levels 4,8 registered with a, ~b, cin
//     S3: level 16, result formation, output registers
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  operand handshake (a, b, bin)
//     out_valid / out_ready result handshake (diff, bout, ovf, zero)
//
//   Handshake: a beat moves on a rising edge where valid && ready. in_ready
//   is the global advance enable (!out_valid || out_ready); when it is low
//   every stage holds, so the outputs are stable while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module rd_prefix_subtractor
  import rd_kgp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned TOP_SPAN = 1 << (LEVELS - 1);

  logic en;

  // ---------------- stage registers ----------------
  logic             s1_valid_q, s1_valid_d;
  kgp_vec_t         s1_kgp_q,   s1_kgp_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_nb_q,    s1_nb_d;
  logic             s1_cin_q,   s1_cin_d;

  logic             s2_valid_q, s2_valid_d;
  kgp_vec_t         s2_kgp_q,   s2_kgp_d;
  logic [WIDTH-1:0] s2_a_q,     s2_a_d;
  logic [WIDTH-1:0] s2_nb_q,    s2_nb_d;
  logic             s2_cin_q,   s2_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             bout_q,      bout_d;
  logic             ovf_q,       ovf_d;
  logic             zero_q,      zero_d;

  // ---------------- front end: per-bit kgp ----------------
  logic [WIDTH-1:0] nb;
  logic             cin;
  kgp_vec_t         kgp_raw;
  kgp_vec_t         kgp_l0;
  kgp_vec_t         kgp_l1, kgp_l2, kgp_l4, kgp_l8, kgp_l16;

  always_comb begin
    nb  = ~b;
    cin = ~bin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      // kill 00 (both 0), gen 01 (both 1), prop 11 (exactly one 1)
      kgp_raw[i] = {a[i] ^ nb[i], a[i] | nb[i]};
    end
    kgp_l0 = kgp_raw;
    // The carry-in sits just below bit 0; folding it in here keeps five
    // doubling levels sufficient to reach it from bit 31.
    kgp_l0[0] = kgp_combine(kgp_raw[0], cin ? KGP_GEN : KGP_KILL);
  end

  rd_kgp_level #(.SPAN(1)) u_lvl1 (.kgp_i(kgp_l0), .kgp_o(kgp_l1));
  rd_kgp_level #(.SPAN(2)) u_lvl2 (.kgp_i(kgp_l1), .kgp_o(kgp_l2));

  rd_kgp_level #(.SPAN(4)) u_lvl4 (.kgp_i(s1_kgp_q), .kgp_o(kgp_l4));
  rd_kgp_level #(.SPAN(8)) u_lvl8 (.kgp_i(kgp_l4),   .kgp_o(kgp_l8));

  rd_kgp_level #(.SPAN(TOP_SPAN)) u_lvl16 (.kgp_i(s2_kgp_q), .kgp_o(kgp_l16));

  // ---------------- result formation ----------------
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_calc;

  always_comb begin
    // After the full tree no position propagates any more: each one resolves
    // to generate (carry out of that bit) or kill.
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry[i] = (kgp_l16[i] == KGP_GEN);
    end
    diff_calc = s2_a_q ^ s2_nb_q ^ {carry[WIDTH-2:0], s2_cin_q};
  end

  // ---------------- advance / next state ----------------
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_kgp_d    = s1_kgp_q;
    s1_a_d      = s1_a_q;
    s1_nb_d     = s1_nb_q;
    s1_cin_d    = s1_cin_q;
    s2_valid_d  = s2_valid_q;
    s2_kgp_d    = s2_kgp_q;
    s2_a_d      = s2_a_q;
    s2_nb_d     = s2_nb_q;
    s2_cin_d    = s2_cin_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_kgp_d    = kgp_l2;
      s1_a_d      = a;
      s1_nb_d     = nb;
      s1_cin_d    = cin;
      s2_valid_d  = s1_valid_q;
      s2_kgp_d    = kgp_l8;
      s2_a_d      = s1_a_q;
      s2_nb_d     = s1_nb_q;
      s2_cin_d    = s1_cin_q;
      out_valid_d = s2_valid_q;
      diff_d      = diff_calc;
      bout_d      = ~carry[WIDTH-1];
      // b[31] is ~nb[31]; overflow when operand signs differ and the
      // result sign disagrees with the minuend.
      ovf_d       = (s2_a_q[WIDTH-1] != ~s2_nb_q[WIDTH-1]) &&
                    (diff_calc[WIDTH-1] != s2_a_q[WIDTH-1]);
      zero_d      = (diff_calc == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_kgp_q    <= '0;
      s1_a_q      <= '0;
      s1_nb_q     <= '0;
      s1_cin_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_kgp_q    <= '0;
      s2_a_q      <= '0;
      s2_nb_q     <= '0;
      s2_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_kgp_q    <= s1_kgp_d;
      s1_a_q      <= s1_a_d;
      s1_nb_q     <= s1_nb_d;
      s1_cin_q    <= s1_cin_d;
      s2_valid_q  <= s2_valid_d;
      s2_kgp_q    <= s2_kgp_d;
      s2_a_q      <= s2_a_d;
      s2_nb_q     <= s2_nb_d;
      s2_cin_q    <= s2_cin_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
